// File: rtl/alu_16_pipe.sv
// Registered Hack-style ALU stage with a 2-entry output skid buffer on a valid/ready handshake.
// Define ALU_OVF_EN to add the per-entry signed-add overflow flag and the ovf port.
module alu_16_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [1:0] DEPTH_L = DEPTH[1:0];

  state_t           state;
  logic [1:0]       cnt;
  logic             acc;
  logic             pop;

  logic [WIDTH-1:0] x1, x2, y1, y2, r;
  logic [WIDTH-1:0] new_res;
  logic             new_zr, new_ng;

  // Entry 0 is always the head; entry 1 only holds data in FULL.
  logic [WIDTH-1:0] res0, res1;
  logic             zr0, zr1, ng0, ng1;
`ifdef ALU_OVF_EN
  logic             new_ovf;
  logic             ovf0, ovf1;
`endif

  always_comb begin
    x1      = ctrl[5] ? '0 : x;
    x2      = ctrl[4] ? ~x1 : x1;
    y1      = ctrl[3] ? '0 : y;
    y2      = ctrl[2] ? ~y1 : y1;
    r       = ctrl[1] ? (x2 + y2) : (x2 & y2);
    new_res = ctrl[0] ? ~r : r;
    new_zr  = (new_res == '0);
    new_ng  = new_res[WIDTH-1];
  end

`ifdef ALU_OVF_EN
  assign new_ovf = ctrl[1] & (x2[WIDTH-1] == y2[WIDTH-1]) & (r[WIDTH-1] != x2[WIDTH-1]);
`endif

  assign cnt       = state;
  assign in_ready  = (cnt < DEPTH_L);
  assign out_valid = (state != EMPTY);
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      res0  <= '0;
      res1  <= '0;
      zr0   <= 1'b0;
      zr1   <= 1'b0;
      ng0   <= 1'b0;
      ng1   <= 1'b0;
`ifdef ALU_OVF_EN
      ovf0  <= 1'b0;
      ovf1  <= 1'b0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            res0  <= new_res;
            zr0   <= new_zr;
            ng0   <= new_ng;
`ifdef ALU_OVF_EN
            ovf0  <= new_ovf;
`endif
            state <= ONE;
          end
        end
        ONE: begin
          if (acc && pop) begin
            res0 <= new_res;
            zr0  <= new_zr;
            ng0  <= new_ng;
`ifdef ALU_OVF_EN
            ovf0 <= new_ovf;
`endif
          end else if (acc) begin
            res1  <= new_res;
            zr1   <= new_zr;
            ng1   <= new_ng;
`ifdef ALU_OVF_EN
            ovf1  <= new_ovf;
`endif
            state <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            res0  <= res1;
            zr0   <= zr1;
            ng0   <= ng1;
`ifdef ALU_OVF_EN
            ovf0  <= ovf1;
`endif
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Head outputs forced to zero whenever the buffer is empty.
  assign out = out_valid ? res0 : '0;
  assign zr  = out_valid & zr0;
  assign ng  = out_valid & ng0;
`ifdef ALU_OVF_EN
  assign ovf = out_valid & ovf0;
`endif

endmodule
